// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types, constants and arm-FSM helper for the program/address counter
package pc_pkg;

    localparam int WIDTH   = 16;
    localparam int STAGES  = WIDTH / 4;
    localparam int T_CLK_Q = 10;
    localparam int T_RCO   = 10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2,
        FULL  = 2'd3
    } arm_state_t;

    // A commit empties the shadows first; loads on the same edge then re-arm from EMPTY.
    function automatic arm_state_t arm_next(
        input arm_state_t cur,
        input logic       commit,
        input logic       ld_lo,
        input logic       ld_hi
    );
        arm_state_t base;
        arm_state_t nxt;
        base = commit ? EMPTY : cur;
        nxt  = base;
        if (ld_lo && ld_hi) begin
            nxt = FULL;
        end else if (ld_lo) begin
            if (base == HI || base == FULL) begin
                nxt = FULL;
            end else begin
                nxt = LO;
            end
        end else if (ld_hi) begin
            if (base == LO || base == FULL) begin
                nxt = FULL;
            end else begin
                nxt = HI;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pc_nibble.sv
// rtl/pc_nibble.sv - 4-bit synchronous counter stage with parallel load and ripple-carry output
module pc_nibble
    import pc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       enp,
    input  logic       ent,
    input  logic [3:0] p,
    output logic [3:0] q,
    output logic       rco
);

`ifdef PC_GATE_DELAY_EN
    // Delays mirror the discrete 74xx stage so board-level timing can be studied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= #T_CLK_Q 4'h0;
        end else if (load) begin
            q <= #T_CLK_Q p;
        end else if (enp && ent) begin
            q <= #T_CLK_Q q + 4'h1;
        end
    end

    assign #T_RCO rco = ent & (q == 4'hF);
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'h0;
        end else if (load) begin
            q <= p;
        end else if (enp && ent) begin
            q <= q + 4'h1;
        end
    end

    assign rco = ent & (q == 4'hF);
`endif

endmodule

// File: rtl/pc_address_counter.sv
// rtl/pc_address_counter.sv - 16-bit program counter with byte-loaded jump target; PC_GATE_DELAY_EN adds stage delays
module pc_address_counter
    import pc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             ld_lo,
    input  logic             ld_hi,
    input  logic             jump,
    input  logic [7:0]       d,
    output logic [WIDTH-1:0] pc,
    output logic             co,
    output logic             armed,
    output logic             jump_err
);

    arm_state_t        state;
    logic [7:0]        shadow_lo;
    logic [7:0]        shadow_hi;
    logic              commit;
    logic [WIDTH-1:0]  target;
    logic [STAGES-1:0] rco;

    assign armed  = (state == FULL);
    assign commit = jump & armed;
    assign target = {shadow_hi, shadow_lo};

    // The stages load the pre-edge shadows, so same-edge byte writes only affect the next target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_lo <= 8'h00;
            shadow_hi <= 8'h00;
        end else begin
            if (ld_lo) begin
                shadow_lo <= d;
            end
            if (ld_hi) begin
                shadow_hi <= d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            jump_err <= 1'b0;
        end else begin
            state    <= arm_next(state, commit, ld_lo, ld_hi);
            jump_err <= jump & ~armed;
        end
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic stage_ent;
            if (k == 0) begin : g_first
                assign stage_ent = inc;
            end else begin : g_rest
                assign stage_ent = rco[k-1];
            end

            pc_nibble u_nibble (
                .clk  (clk),
                .rst  (rst),
                .load (commit),
                .enp  (inc),
                .ent  (stage_ent),
                .p    (target[4*k +: 4]),
                .q    (pc[4*k +: 4]),
                .rco  (rco[k])
            );
        end
    endgenerate

    assign co = rco[STAGES-1] & ~rst;

endmodule

// File: tb/tb_pc_address_counter.sv
// tb/tb_pc_address_counter.sv - directed plus randomized check of pc_address_counter against a byte-level model
module tb_pc_address_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inc;
    logic        ld_lo;
    logic        ld_hi;
    logic        jump;
    logic [7:0]  d;
    logic [15:0] pc;
    logic        co;
    logic        armed;
    logic        jump_err;

    int n_cmp = 0;
    int n_err = 0;

    // Model: target halves plus "written since last commit" flags.
    int m_pc;
    int m_sh_lo;
    int m_sh_hi;
    bit m_lo_w;
    bit m_hi_w;
    bit m_err;

    always #100 clk = ~clk;

    pc_address_counter dut (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .ld_lo    (ld_lo),
        .ld_hi    (ld_hi),
        .jump     (jump),
        .d        (d),
        .pc       (pc),
        .co       (co),
        .armed    (armed),
        .jump_err (jump_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_sh_lo = 0;
        m_sh_hi = 0;
        m_lo_w  = 1'b0;
        m_hi_w  = 1'b0;
        m_err   = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit i, input bit l, input bit h, input bit j,
                        input logic [7:0] dv, input string tag);
        bit full;
        inc   = i;
        ld_lo = l;
        ld_hi = h;
        jump  = j;
        d     = dv;
        #60;
        full = m_lo_w && m_hi_w;
        chk({tag, ":co"}, 32'(co), 32'(i && (m_pc == 16'hFFFF)));
        chk({tag, ":armed_pre"}, 32'(armed), 32'(full));
        @(posedge clk);
        m_err = j && !full;
        if (j && full) begin
            m_pc   = m_sh_hi * 256 + m_sh_lo;
            m_lo_w = 1'b0;
            m_hi_w = 1'b0;
        end else if (i) begin
            m_pc = (m_pc + 1) % 65536;
        end
        if (l) begin
            m_lo_w  = 1'b1;
            m_sh_lo = int'(dv);
        end
        if (h) begin
            m_hi_w  = 1'b1;
            m_sh_hi = int'(dv);
        end
        @(negedge clk);
        inc   = 1'b0;
        ld_lo = 1'b0;
        ld_hi = 1'b0;
        jump  = 1'b0;
        chk({tag, ":pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ":armed"}, 32'(armed), 32'(m_lo_w && m_hi_w));
        chk({tag, ":jump_err"}, 32'(jump_err), 32'(m_err));
    endtask

    task automatic load_pc(input logic [15:0] v, input string tag);
        step(1'b0, 1'b1, 1'b0, 1'b0, v[7:0],  {tag, ":lo"});
        step(1'b0, 1'b0, 1'b1, 1'b0, v[15:8], {tag, ":hi"});
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00,   {tag, ":jump"});
    endtask

    initial begin
        rst   = 1'b1;
        inc   = 1'b1;
        ld_lo = 1'b0;
        ld_hi = 1'b0;
        jump  = 1'b0;
        d     = 8'h00;
        model_reset();
        #30;
        chk("reset:pc", 32'(pc), 32'h0);
        chk("reset:armed", 32'(armed), 32'h0);
        chk("reset:jump_err", 32'(jump_err), 32'h0);
        chk("reset:co_held", 32'(co), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        inc = 1'b0;

        // Byte load then commit.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h34, "load_lo");
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h12, "load_hi");
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "commit");
        chk("commit:pc1234", 32'(pc), 32'h1234);

        // Async reset mid-count while half armed, no clock edge needed.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, "half_arm");
        inc = 1'b1;
        #20;
        rst = 1'b1;
        #20;
        chk("async_rst:pc", 32'(pc), 32'h0);
        chk("async_rst:armed", 32'(armed), 32'h0);
        chk("async_rst:co", 32'(co), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        inc = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h66, "post_rst_hi");
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "post_rst_jump");

        // Multi-stage carry and full wrap.
        load_pc(16'h00FF, "pre00FF");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "carry");
        chk("carry:pc0100", 32'(pc), 32'h0100);
        load_pc(16'hFFFF, "preFFFF");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "wrap");
        chk("wrap:pc0000", 32'(pc), 32'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "after_wrap");

        // Premature jump with inc: increments, flags error, keeps HI.
        load_pc(16'h0010, "pre0010");
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hAB, "prem_hi");
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "prem_jump");
        chk("prem:pc0011", 32'(pc), 32'h0011);
        chk("prem:err_pulse", 32'(jump_err), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "prem_idle");
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hCD, "prem_lo");
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "prem_commit");
        chk("prem:pcABCD", 32'(pc), 32'hABCD);

        // Commit, load and inc on one edge.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h78, "sim_lo");
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h56, "sim_hi");
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h9A, "sim_all");
        chk("sim:pc5678", 32'(pc), 32'h5678);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h11, "sim_rearm");
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "sim_commit");
        chk("sim:pc119A", 32'(pc), 32'h119A);

        // Randomized traffic, including a stretch near the top of the range.
        for (int n = 0; n < 200; n++) begin
            step(($urandom % 2) == 1, ($urandom % 4) == 0, ($urandom % 4) == 0,
                 ($urandom % 5) == 0, 8'($urandom_range(255)), "rand_a");
        end
        load_pc(16'hFFF8, "preFFF8");
        for (int n = 0; n < 100; n++) begin
            step(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
                 ($urandom % 8) == 0, 8'($urandom_range(255)), "rand_b");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
